cache_ctrl: RTL

//   Direct-mapped, write-through, no-write-allocate cache controller.

---
 rtl/cache_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through no-write-allocate cache controller
module cache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  c_clk,
    input  logic                  sys_rst,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic                  c_wr,
    input  logic                  c_rd,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [DATA_W/8-1:0]   c_bval,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_ack,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_wr,
    output logic                  m_rd,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_bval,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ack,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   bval_q, bval_d;
    logic              is_wr_q, is_wr_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic              c_ack_q, c_ack_d;
    logic              m_rd_q, m_rd_d;
    logic              m_wr_q, m_wr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [TAG_W-1:0]  tag_d [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [DATA_W-1:0] data_d [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic [CNT_W-1:0]   cnt_one;

    assign idx     = addr_q[INDEX_W+1:2];
    assign req_tag = addr_q[ADDR_W-1:INDEX_W+2];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bval_d     = bval_q;
        is_wr_d    = is_wr_q;
        c_rdata_d  = c_rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        c_ack_d    = 1'b0;
        m_rd_d     = 1'b0;
        m_wr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (c_wr || c_rd) begin
                    addr_d  = c_addr & ~ADDR_W'(3);
                    wdata_d = c_wdata;
                    bval_d  = c_bval;
                    is_wr_d = c_wr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (is_wr_q) begin
                    // Write-through: a hit updates the line in place, a miss leaves the cache alone.
                    if (hit) begin
                        for (int b = 0; b < BE_W; b++) begin
                            if (bval_q[b]) data_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                    m_wr_d  = 1'b1;
                    state_d = S_MEM_WR;
                end else if (hit) begin
                    c_rdata_d = data_q[idx];
                    hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + cnt_one;
                    c_ack_d   = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + cnt_one;
                    m_rd_d     = 1'b1;
                    state_d    = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (m_ack) begin
                    data_d[idx]  = m_rdata;
                    tag_d[idx]   = req_tag;
                    valid_d[idx] = 1'b1;
                    c_rdata_d    = m_rdata;
                    c_ack_d      = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    m_rd_d = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (m_ack) begin
                    c_ack_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    m_wr_d = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (!sys_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            bval_q     <= '0;
            is_wr_q    <= 1'b0;
            c_rdata_q  <= '0;
            c_ack_q    <= 1'b0;
            m_rd_q     <= 1'b0;
            m_wr_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bval_q     <= bval_d;
            is_wr_q    <= is_wr_d;
            c_rdata_q  <= c_rdata_d;
            c_ack_q    <= c_ack_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data survive reset; only valid bits are cleared.
    always_ff @(posedge c_clk) begin
        if (sys_rst) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign c_rdata  = c_rdata_q;
    assign c_ack    = c_ack_q;
    assign m_addr   = addr_q;
    assign m_wr     = m_wr_q;
    assign m_rd     = m_rd_q;
    assign m_wdata  = wdata_q;
    assign m_bval   = bval_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
endmodule
